// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: compacts fetch groups into a circular buffer and presents the oldest entries to decode.
// Optional fetch-stall counter enabled by defining FETCHQ_PERF_CNT_EN.
module fetch_queue #(
    parameter int INSTR_PER_FETCH = 4,
    parameter int ILEN            = 32,
    parameter int XLEN            = 32,
    parameter int DEPTH           = 16,
    parameter int DEQ_WIDTH       = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic                            fe_valid_i,
    output logic                            fe_ready_o,
    input  logic [XLEN-1:0]                 fe_pc_i,
    input  logic [INSTR_PER_FETCH-1:0]      fe_slot_mask_i,
    input  logic [INSTR_PER_FETCH*ILEN-1:0] fe_instrs_i,
    output logic [DEQ_WIDTH-1:0]            de_valid_o,
    output logic [DEQ_WIDTH*ILEN-1:0]       de_instr_o,
    output logic [DEQ_WIDTH*XLEN-1:0]       de_pc_o,
    input  logic [$clog2(DEQ_WIDTH+1)-1:0]  de_accept_i,
    output logic [31:0]                     stall_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int POP_W = $clog2(INSTR_PER_FETCH + 1);

    logic [ILEN-1:0]  instr_mem [DEPTH];
    logic [XLEN-1:0]  pc_mem    [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [POP_W-1:0] slot_off [INSTR_PER_FETCH];
    logic [POP_W-1:0] pop;
    logic [CNT_W-1:0] enq_n;
    logic [CNT_W-1:0] deq_n;
    logic [CNT_W-1:0] accept_ext;
    logic             enq;

    // Ready looks only at the registered count so it never depends on decode.
    assign fe_ready_o = (count <= CNT_W'(DEPTH - INSTR_PER_FETCH));
    assign enq        = fe_valid_i & fe_ready_o & ~flush_i;

    // Each valid slot lands at tail plus the number of valid slots below it.
    always_comb begin
        pop = '0;
        for (int k = 0; k < INSTR_PER_FETCH; k++) begin
            slot_off[k] = pop;
            pop         = pop + POP_W'(fe_slot_mask_i[k]);
        end
    end

    assign enq_n      = enq ? CNT_W'(pop) : '0;
    assign accept_ext = CNT_W'(de_accept_i);
    assign deq_n      = (accept_ext > count) ? count : accept_ext;

    always_ff @(posedge clk_i) begin
        if (enq) begin
            for (int k = 0; k < INSTR_PER_FETCH; k++) begin
                if (fe_slot_mask_i[k]) begin
                    instr_mem[tail + PTR_W'(slot_off[k])] <= fe_instrs_i[k*ILEN +: ILEN];
                    pc_mem[tail + PTR_W'(slot_off[k])]    <= fe_pc_i + XLEN'(4 * k);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq_n);
            tail  <= tail + PTR_W'(enq_n);
            count <= count + enq_n - deq_n;
        end
    end

    always_comb begin
        de_valid_o = '0;
        de_instr_o = '0;
        de_pc_o    = '0;
        for (int k = 0; k < DEQ_WIDTH; k++) begin
            de_valid_o[k]            = (CNT_W'(k) < count);
            de_instr_o[k*ILEN +: ILEN] = instr_mem[head + PTR_W'(k)];
            de_pc_o[k*XLEN +: XLEN]    = pc_mem[head + PTR_W'(k)];
        end
    end

`ifdef FETCHQ_PERF_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (fe_valid_i && !fe_ready_o && !flush_i && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = 32'h0;
`endif

    // Decode may only consume lanes that are actually presented.
    assert property (@(posedge clk_i) disable iff (rst_i)
        !flush_i |-> (int'(de_accept_i) <= ((int'(count) < DEQ_WIDTH) ? int'(count) : DEQ_WIDTH)));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_fetch_queue;

    localparam int IPF   = 4;
    localparam int ILEN  = 32;
    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int DEQ   = 4;
    localparam int AW    = $clog2(DEQ + 1);

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } ent_t;

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic                 flush_i;
    logic                 fe_valid_i;
    logic                 fe_ready_o;
    logic [XLEN-1:0]      fe_pc_i;
    logic [IPF-1:0]       fe_slot_mask_i;
    logic [IPF*ILEN-1:0]  fe_instrs_i;
    logic [DEQ-1:0]       de_valid_o;
    logic [DEQ*ILEN-1:0]  de_instr_o;
    logic [DEQ*XLEN-1:0]  de_pc_o;
    logic [AW-1:0]        de_accept_i;
    logic [31:0]          stall_cnt_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    ent_t        q[$];
    logic [31:0] exp_stall = 32'h0;

    fetch_queue #(
        .INSTR_PER_FETCH(IPF), .ILEN(ILEN), .XLEN(XLEN), .DEPTH(DEPTH), .DEQ_WIDTH(DEQ)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .fe_valid_i(fe_valid_i), .fe_ready_o(fe_ready_o), .fe_pc_i(fe_pc_i),
        .fe_slot_mask_i(fe_slot_mask_i), .fe_instrs_i(fe_instrs_i),
        .de_valid_o(de_valid_o), .de_instr_o(de_instr_o), .de_pc_o(de_pc_o),
        .de_accept_i(de_accept_i), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_ready();
        return (DEPTH - q.size()) >= IPF;
    endfunction

    // Reference behaviour for one clock edge, evaluated from the inputs currently applied.
    task automatic model_step();
        bit rdy = model_ready();
        if (rst_i) begin
            q.delete();
            exp_stall = 32'h0;
        end else if (flush_i) begin
            q.delete();
        end else begin
`ifdef FETCHQ_PERF_CNT_EN
            if (fe_valid_i && !rdy && exp_stall != 32'hFFFF_FFFF) exp_stall++;
`endif
            for (int i = 0; i < int'(de_accept_i); i++) void'(q.pop_front());
            if (fe_valid_i && rdy) begin
                for (int k = 0; k < IPF; k++) begin
                    if (fe_slot_mask_i[k]) q.push_back({fe_instrs_i[k*ILEN +: ILEN], fe_pc_i + 32'(4 * k)});
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("fe_ready", 64'(fe_ready_o), 64'(model_ready()));
        chk("stall_cnt", 64'(stall_cnt_o), 64'(exp_stall));
        for (int k = 0; k < DEQ; k++) begin
            chk($sformatf("de_valid[%0d]", k), 64'(de_valid_o[k]), 64'(k < q.size()));
            if (k < q.size()) begin
                chk($sformatf("de_instr[%0d]", k), 64'(de_instr_o[k*ILEN +: ILEN]), 64'(q[k].instr));
                chk($sformatf("de_pc[%0d]", k), 64'(de_pc_o[k*XLEN +: XLEN]), 64'(q[k].pc));
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic step(input logic v, input logic [31:0] pc, input logic [IPF-1:0] mask,
                        input int acc, input logic fl, input logic r);
        rst_i          = r;
        flush_i        = fl;
        fe_valid_i     = v;
        fe_pc_i        = pc;
        fe_slot_mask_i = mask;
        de_accept_i    = AW'(acc);
        for (int k = 0; k < IPF; k++) fe_instrs_i[k*ILEN +: ILEN] = $urandom;
        tick();
    endtask

    task automatic idle(input int acc);
        step(1'b0, 32'h0, '0, acc, 1'b0, 1'b0);
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; fe_valid_i = 1'b0; fe_pc_i = '0;
        fe_slot_mask_i = '0; fe_instrs_i = '0; de_accept_i = '0;

        // Reset state
        step(1'b0, 32'h0, '0, 0, 1'b0, 1'b1);
        step(1'b0, 32'h0, '0, 0, 1'b0, 1'b1);
        chk("rst_valid", 64'(de_valid_o), 64'h0);
        chk("rst_ready", 64'(fe_ready_o), 64'h1);
        chk("rst_stall", 64'(stall_cnt_o), 64'h0);

        // Full group at 0x8000_0000
        step(1'b1, 32'h8000_0000, 4'b1111, 0, 1'b0, 1'b0);
        chk("full_valid", 64'(de_valid_o), 64'hF);
        chk("full_pc0", 64'(de_pc_o[0 +: 32]), 64'h8000_0000);
        chk("full_pc3", 64'(de_pc_o[96 +: 32]), 64'h8000_000C);
        idle(4);

        // Sparse group: compaction of slots 1 and 3
        step(1'b1, 32'h100, 4'b1010, 0, 1'b0, 1'b0);
        chk("sparse_valid", 64'(de_valid_o), 64'h3);
        chk("sparse_pc0", 64'(de_pc_o[0 +: 32]), 64'h104);
        chk("sparse_pc1", 64'(de_pc_o[32 +: 32]), 64'h10C);
        step(1'b1, 32'h200, 4'b0000, 2, 1'b0, 1'b0);
        chk("empty_mask", 64'(de_valid_o), 64'h0);

        // Fill to DEPTH, then stall with fetch held valid
        for (int g = 0; g < 4; g++) step(1'b1, 32'h1000 + 32'(16 * g), 4'b1111, 0, 1'b0, 1'b0);
        chk("fill_ready", 64'(fe_ready_o), 64'h0);
        for (int c = 0; c < 7; c++) step(1'b1, 32'h2000, 4'b1111, 0, 1'b0, 1'b0);
`ifdef FETCHQ_PERF_CNT_EN
        chk("stall_7", 64'(stall_cnt_o), 64'd7);
`else
        chk("stall_off", 64'(stall_cnt_o), 64'd0);
`endif
        idle(4);
        chk("drain_ready", 64'(fe_ready_o), 64'h1);
        chk("drain_pc0", 64'(de_pc_o[0 +: 32]), 64'h1010);
        for (int c = 0; c < 3; c++) idle(4);

        // Wrap: bring head and tail to 14, then enqueue across the boundary
        step(1'b0, 32'h0, '0, 0, 1'b0, 1'b1);
        for (int g = 0; g < 3; g++) step(1'b1, 32'h3000, 4'b1111, 0, 1'b0, 1'b0);
        step(1'b1, 32'h3100, 4'b0011, 0, 1'b0, 1'b0);
        idle(4); idle(4); idle(4); idle(2);
        step(1'b1, 32'h200, 4'b1111, 0, 1'b0, 1'b0);
        chk("wrap_valid", 64'(de_valid_o), 64'hF);
        chk("wrap_pc1", 64'(de_pc_o[32 +: 32]), 64'h204);
        idle(2);
        chk("wrap_pc_after", 64'(de_pc_o[0 +: 32]), 64'h208);
        idle(2);

        // Flush with nine entries and a concurrent fetch group
        step(1'b1, 32'h4000, 4'b1111, 0, 1'b0, 1'b0);
        step(1'b1, 32'h4010, 4'b1111, 0, 1'b0, 1'b0);
        step(1'b1, 32'h4020, 4'b0001, 0, 1'b0, 1'b0);
        step(1'b1, 32'h5000, 4'b1111, 2, 1'b1, 1'b0);
        chk("flush_valid", 64'(de_valid_o), 64'h0);
        chk("flush_ready", 64'(fe_ready_o), 64'h1);
        idle(0);
        chk("flush_stays", 64'(de_valid_o), 64'h0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            int maxn = (q.size() < DEQ) ? q.size() : DEQ;
            logic [31:0] pc = ($urandom_range(15, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            step(1'($urandom_range(3, 0) != 0), pc, IPF'($urandom),
                 $urandom_range(maxn, 0), 1'($urandom_range(39, 0) == 0),
                 1'($urandom_range(199, 0) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
